exc_pc_ctrl: RTL
================

Name: exc_pc_ctrl

Overview:
Exception/interrupt sequencer that drives the 3-bit PCSrc select of the next-PC unit in the single-cycle MIPS core. It arbitrates between three sources: the decoder's normal PCSrc, an external interrupt request (timer/peripheral) and illegal-opcode exceptions. When it takes an interrupt or exception, it saves the return address into $26 ($k0/XP) and aborts the current instruction's side effects. Kernel mode is defined by PC[31].

Parameters:
SYNC_STAGES, 2, flops in irq synchronizer chain (>=2)
HOLDOFF, 1, instructions guaranteed to execute in user mode after leaving kernel before an irq may be taken (0..15)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous active-low reset
pc  in  32  current PC register value
pcsrc_dec  in  3  decoder PCSrc (000 normal, 001 branch, 010 jump, 011 DataBusA)
illegal_op  in  1  decoder flags current instruction undefined
irq  in  1  asynchronous interrupt request, rising-edge significant
PCSrc  out  3  select to next-PC unit (adds 100 ILLOP/interrupt, 101 XADR/exception)
xp_we  out  1  write xp_data into register $26 this cycle
xp_data  out  32  return address to save
abort  out  1  suppress RegWrite/MemWrite of current instruction
kernel  out  1  pc[31]
irq_pending  out  1  latched, not yet serviced interrupt
double_fault  out  1  sticky: illegal_op executed in kernel mode

Behaviour:
- Reset (reset=0, async): sync chain, irq_prev, irq_pending, holdoff_cnt, kernel_q and double_fault are cleared. Combinational outputs follow their inputs. With the post-reset pc=0x00400000: kernel=0 and PCSrc=pcsrc_dec.
- irq path: SYNC_STAGES flops -> irq_s, plus a registered irq_prev. Edge = irq_s & ~irq_prev. On edge, irq_pending <= 1 at the next clk.
- irq_pending clears on the clk edge that ends a cycle with take_irq=1. If a new edge is detected in that same cycle, set wins and pending stays 1.
- kernel = pc[31]. kernel_q is kernel registered.
- Holdoff:
  - On each clk with kernel_q=1 and kernel=0 (the first user instruction after a kernel-to-user transition), holdoff_cnt <= HOLDOFF-1 if HOLDOFF>0.
  - Otherwise holdoff_cnt decrements each clk while it is nonzero and kernel=0.
  - irq_allowed = ~kernel & (holdoff_cnt==0) & ~(kernel_q & ~kernel & HOLDOFF>0).
- Priority, evaluated combinationally each cycle:
  1. illegal_op & ~kernel: take_exc. PCSrc=101, xp_we=1, xp_data=pc+4, abort=1.
  2. illegal_op & kernel: PCSrc=101, xp_we=0 (so $26 is not clobbered), abort=1. double_fault <= 1 at clk and stays sticky until reset.
  3. irq_pending & irq_allowed: take_irq. PCSrc=100, xp_we=1, xp_data=pc (the instruction is re-executed on return), abort=1.
  4. Otherwise: PCSrc=pcsrc_dec, xp_we=0, abort=0, xp_data=pc+4 (don't care).
- If illegal_op and an irq are pending in the same cycle, the exception is taken and irq_pending is held. The irq is then blocked while in kernel mode.
- Interrupts are never taken while kernel=1. Pending requests persist and are serviced after the holdoff expires.
- Arithmetic: pc+4 is a 32-bit wrap (0xFFFFFFFC+4 = 0).
- pcsrc_dec values 100/101 are passed through unchanged under case 4.
- Latency: irq pin rising edge to PCSrc=100 is at minimum SYNC_STAGES+1 clk edges in user mode with holdoff=0 (irq_pending visible in the cycle after the edge is detected).
- Return from kernel is `jr $26` (decoder PCSrc=011). No special handling beyond the holdoff.

Test Plan:
- Reset mid-run with irq_pending=1 and double_fault=1 -> both 0 immediately (async), PCSrc=pcsrc_dec=000.
- User mode, pc=0x00400010, pulse irq -> PCSrc=100 in the 4th cycle after the pulse (SYNC_STAGES=2), xp_we=1, xp_data=0x00400010, abort=1. irq_pending=0 the next cycle.
- pc=0x00400020, illegal_op=1 -> PCSrc=101, xp_data=0x00400024, xp_we=1, abort=1. Same in kernel (pc=0x80000100) -> xp_we=0, double_fault=1 sticky.
- irq pulse while pc=0x80000050 -> irq_pending=1, PCSrc follows pcsrc_dec. After the jump to pc=0x00400030 with HOLDOFF=1 -> first user cycle PCSrc=pcsrc_dec, second user cycle PCSrc=100 with xp_data equal to that cycle's pc.
- illegal_op and irq_pending together in user mode -> PCSrc=101, irq_pending stays 1.
- Branch passthrough: pcsrc_dec=001, no events -> PCSrc=001, xp_we=0, abort=0. Irq held high for 10 cycles -> only one interrupt taken (edge semantics).

Source files
------------

// File: rtl/exc_pc_ctrl.sv
// Exception/interrupt sequencer for the single-cycle MIPS next-PC select.
// Arbitrates decoder PCSrc, synchronized edge-triggered irq and illegal-opcode traps.
module exc_pc_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [2:0]  pcsrc_dec,
  input  logic        illegal_op,
  input  logic        irq,
  output logic [2:0]  PCSrc,
  output logic        xp_we,
  output logic [31:0] xp_data,
  output logic        abort,
  output logic        kernel,
  output logic        irq_pending,
  output logic        double_fault
);

  localparam logic [2:0] PCSRC_ILLOP = 3'b100;
  localparam logic [2:0] PCSRC_XADR  = 3'b101;
  localparam logic       HOLDOFF_EN  = (HOLDOFF > 0);
  localparam logic [3:0] HOLDOFF_RELOAD = HOLDOFF_EN ? 4'(HOLDOFF - 1) : 4'd0;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   irq_prev_r;
  logic                   irq_pending_r;
  logic [3:0]             holdoff_cnt_r;
  logic                   kernel_q_r;
  logic                   double_fault_r;

  logic        kernel_s;
  logic        irq_s;
  logic        irq_edge_s;
  logic        leaving_kernel_s;
  logic        irq_allowed_s;
  logic        take_irq_s;
  logic [31:0] pc_plus4_s;
  logic [2:0]  pcsrc_s;
  logic        xp_we_s;
  logic [31:0] xp_data_s;
  logic        abort_s;

  assign kernel_s         = pc[31];
  assign irq_s            = sync_r[SYNC_STAGES-1];
  assign irq_edge_s       = irq_s & ~irq_prev_r;
  assign leaving_kernel_s = kernel_q_r & ~kernel_s;
  assign irq_allowed_s    = ~kernel_s & (holdoff_cnt_r == 4'd0) & ~(leaving_kernel_s & HOLDOFF_EN);
  assign pc_plus4_s       = pc + 32'd4;

  // Priority arbitration: user trap, kernel trap, interrupt, then decoder passthrough.
  always_comb begin
    pcsrc_s    = pcsrc_dec;
    xp_we_s    = 1'b0;
    xp_data_s  = pc_plus4_s;
    abort_s    = 1'b0;
    take_irq_s = 1'b0;
    if (illegal_op) begin
      pcsrc_s = PCSRC_XADR;
      xp_we_s = ~kernel_s;
      abort_s = 1'b1;
    end else if (irq_pending_r && irq_allowed_s) begin
      pcsrc_s    = PCSRC_ILLOP;
      xp_we_s    = 1'b1;
      xp_data_s  = pc;
      abort_s    = 1'b1;
      take_irq_s = 1'b1;
    end else begin
      pcsrc_s = pcsrc_dec;
    end
  end

  // Irq synchronizer chain and previous-sample register for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r     <= '0;
      irq_prev_r <= 1'b0;
    end else begin
      sync_r     <= {sync_r[SYNC_STAGES-2:0], irq};
      irq_prev_r <= irq_s;
    end
  end

  // Pending latch: a fresh edge wins over the clear from a taken interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_pending_r <= 1'b0;
    end else if (irq_edge_s) begin
      irq_pending_r <= 1'b1;
    end else if (take_irq_s) begin
      irq_pending_r <= 1'b0;
    end else begin
      irq_pending_r <= irq_pending_r;
    end
  end

  // Kernel history and user-mode holdoff counter after leaving the kernel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kernel_q_r    <= 1'b0;
      holdoff_cnt_r <= 4'd0;
    end else begin
      kernel_q_r <= kernel_s;
      if (leaving_kernel_s && HOLDOFF_EN) begin
        holdoff_cnt_r <= HOLDOFF_RELOAD;
      end else if (holdoff_cnt_r != 4'd0 && !kernel_s) begin
        holdoff_cnt_r <= holdoff_cnt_r - 4'd1;
      end else begin
        holdoff_cnt_r <= holdoff_cnt_r;
      end
    end
  end

  // Sticky flag for an undefined instruction executed inside the kernel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      double_fault_r <= 1'b0;
    end else if (illegal_op && kernel_s) begin
      double_fault_r <= 1'b1;
    end else begin
      double_fault_r <= double_fault_r;
    end
  end

  assign PCSrc        = pcsrc_s;
  assign xp_we        = xp_we_s;
  assign xp_data      = xp_data_s;
  assign abort        = abort_s;
  assign kernel       = kernel_s;
  assign irq_pending  = irq_pending_r;
  assign double_fault = double_fault_r;

endmodule
